i2c_master_nbyte: RTL and testbench

- Parametrised successor to the fixed 16-bit I2C master generator: single-master, 7-bit addressing, transfers 0..NBYTES data bytes per transaction.
- Adds a programmable SCL divider, slave-NACK detection with early STOP, a per-transaction byte count, and BUSY/DONE handshaking.
- Sits between a register/control front end and the open-drain pad logic (SDA_OUT/SDA_OE/SDA_IN, SCL).

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bit_timer.sv | 52 +++++
 rtl/i2c_master_nbyte.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the N-byte I2C master: FSM states, SCL quarter-phase
// indices and the R/W bit encoding.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WACK,
    ST_READ,
    ST_MACK,
    ST_STOP
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_LOW0  = 2'd0;
  localparam phase_t PH_LOW1  = 2'd1;
  localparam phase_t PH_HIGH0 = 2'd2;
  localparam phase_t PH_HIGH1 = 2'd3;

  localparam int DEFAULT_CLK_DIV = 4;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit-time generator: CLK_DIV prescaler feeding a 2-bit quarter-phase counter.
// Held at phase 0 whenever the master is not busy.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output phase_t phase,
  output logic   bit_end,
  output logic   sample
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  phase_t        phase_q, phase_d;
  logic          quarter_end;

  assign quarter_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en) begin
      div_d   = '0;
      phase_d = PH_LOW0;
    end else if (quarter_end) begin
      div_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= PH_LOW0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign bit_end = en && quarter_end && (phase_q == PH_HIGH1);
  assign sample  = en && quarter_end && (phase_q == PH_HIGH0);

endmodule

// File: rtl/i2c_master_nbyte.sv
// Single-master 7-bit-address I2C engine moving 0..NBYTES bytes per transaction,
// with slave-NACK early STOP and BUSY/DONE handshake.
module i2c_master_nbyte
  import i2c_pkg::*;
#(
  parameter  int NBYTES  = 2,
  parameter  int CLK_DIV = DEFAULT_CLK_DIV,
  localparam int BW      = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                START_STB,
  input  logic                RNW,
  input  logic [6:0]          I2C_ADDR,
  input  logic [BW-1:0]       NUM_BYTES,
  input  logic [8*NBYTES-1:0] WR_DATA,
  input  logic                SDA_IN,
  output logic [8*NBYTES-1:0] RD_DATA,
  output logic                SDA_OUT,
  output logic                SDA_OE,
  output logic                SCL,
  output logic                BUSY,
  output logic                DONE,
  output logic                NACK
);

  state_e              state_q, state_d;
  logic                rnw_q, rnw_d;
  logic [6:0]          addr_q, addr_d;
  logic [BW-1:0]       nbytes_q, nbytes_d;
  logic [8*NBYTES-1:0] wr_q, wr_d;
  logic [8*NBYTES-1:0] rd_q, rd_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                ack_q, ack_d;
  logic                nack_q, nack_d;
  logic                done_q, done_d;

  phase_t phase;
  logic   bit_end;
  logic   sample;
  logic   busy;
  logic   last_byte;

  // Byte 0 is the most significant byte of the payload vectors.
  function automatic logic [7:0] wr_byte(input logic [8*NBYTES-1:0] data,
                                         input logic [BW-1:0] k);
    wr_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++)
      if (k == BW'(i)) wr_byte = data[8*(NBYTES-1-i) +: 8];
  endfunction

  assign busy      = (state_q != ST_IDLE);
  assign last_byte = ((byte_cnt_q + BW'(1)) == nbytes_q);

  i2c_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (RESET),
    .en     (busy),
    .phase  (phase),
    .bit_end(bit_end),
    .sample (sample)
  );

  always_comb begin
    state_d    = state_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    nbytes_d   = nbytes_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ack_d      = sample ? SDA_IN : ack_q;
    nack_d     = nack_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START_STB) begin
          state_d    = ST_START;
          rnw_d      = RNW;
          addr_d     = I2C_ADDR;
          nbytes_d   = (NUM_BYTES > BW'(NBYTES)) ? BW'(NBYTES) : NUM_BYTES;
          wr_d       = WR_DATA;
          rd_d       = '0;
          nack_d     = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_ADDR;
          shift_d   = {addr_q, rnw_q};
          bit_cnt_d = '0;
        end
      end
      ST_ADDR, ST_WRITE: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_ADDR_ACK: begin
        if (bit_end) begin
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else if (nbytes_q == '0) begin
            state_d = ST_STOP;
          end else if (rnw_q == I2C_READ) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
            shift_d = wr_byte(wr_q, '0);
          end
        end
      end
      ST_WACK: begin
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
            bit_cnt_d  = '0;
            if (last_byte) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_WRITE;
              shift_d = wr_byte(wr_q, byte_cnt_q + BW'(1));
            end
          end
        end
      end
      ST_READ: begin
        if (sample) shift_d = {shift_q[6:0], SDA_IN};
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_MACK;
            for (int i = 0; i < NBYTES; i++)
              if (byte_cnt_q == BW'(i)) rd_d[8*(NBYTES-1-i) +: 8] = shift_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_MACK: begin
        if (bit_end) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          bit_cnt_d  = '0;
          state_d    = last_byte ? ST_STOP : ST_READ;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      nbytes_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      nbytes_q   <= nbytes_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
    end
  end

  // Bus pins decode from registered state, so SDA only moves on bit boundaries
  // except for the deliberate mid-bit edges of START and STOP.
  always_comb begin
    SCL     = 1'b1;
    SDA_OUT = 1'b1;
    SDA_OE  = 1'b1;
    case (state_q)
      ST_START: SDA_OUT = (phase < PH_HIGH0);
      ST_ADDR, ST_WRITE: begin
        SCL     = phase[1];
        SDA_OUT = shift_q[7];
      end
      ST_ADDR_ACK, ST_WACK, ST_READ: begin
        SCL    = phase[1];
        SDA_OE = 1'b0;
      end
      ST_MACK: begin
        SCL     = phase[1];
        SDA_OUT = last_byte;
      end
      ST_STOP: begin
        SCL     = phase[1];
        SDA_OUT = (phase == PH_HIGH1);
      end
      default: ;
    endcase
  end

  assign BUSY    = busy;
  assign DONE    = done_q;
  assign NACK    = nack_q;
  assign RD_DATA = rd_q;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Self-checking bench: a bit-slot model of each transaction predicts every
// clock of bus activity, the final RD_DATA/NACK and the DONE timing.
module tb_i2c_master_nbyte;

  localparam int NB     = 2;
  localparam int CD     = 4;
  localparam int BW     = $clog2(NB + 1);
  localparam int BITCLK = 4 * CD;

  localparam int K_START = 0;
  localparam int K_MST   = 1;
  localparam int K_SLV   = 2;
  localparam int K_STOP  = 3;

  logic            clk;
  logic            RESET;
  logic            START_STB;
  logic            RNW;
  logic [6:0]      I2C_ADDR;
  logic [BW-1:0]   NUM_BYTES;
  logic [8*NB-1:0] WR_DATA;
  logic            SDA_IN;
  logic [8*NB-1:0] RD_DATA;
  logic            SDA_OUT;
  logic            SDA_OE;
  logic            SCL;
  logic            BUSY;
  logic            DONE;
  logic            NACK;

  int checks = 0;
  int errors = 0;

  // Current transaction as seen by the bench
  logic            tRnw;
  logic [6:0]      tAddr;
  logic [BW-1:0]   tNum;
  logic [8*NB-1:0] tWr;
  logic [8*NB-1:0] tRd;
  logic [NB:0]     tAck;

  int              slotKind[$];
  bit              slotVal[$];
  int              expLen;
  logic [8*NB-1:0] expRd;
  logic            expNack;

  i2c_master_nbyte #(
    .NBYTES (NB),
    .CLK_DIV(CD)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .START_STB(START_STB),
    .RNW      (RNW),
    .I2C_ADDR (I2C_ADDR),
    .NUM_BYTES(NUM_BYTES),
    .WR_DATA  (WR_DATA),
    .SDA_IN   (SDA_IN),
    .RD_DATA  (RD_DATA),
    .SDA_OUT  (SDA_OUT),
    .SDA_OE   (SDA_OE),
    .SCL      (SCL),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .NACK     (NACK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setTxn(input logic rnw, input logic [6:0] addr, input logic [BW-1:0] num,
                        input logic [8*NB-1:0] wr, input logic [8*NB-1:0] rd,
                        input logic [NB:0] ack);
    tRnw = rnw; tAddr = addr; tNum = num; tWr = wr; tRd = rd; tAck = ack;
  endtask

  task automatic randTxn();
    tRnw  = 1'($urandom_range(0, 1));
    tAddr = 7'($urandom);
    tNum  = BW'($urandom_range(0, 3));
    tWr   = (8*NB)'($urandom);
    tRd   = (8*NB)'($urandom);
    for (int i = 0; i <= NB; i++) tAck[i] = ($urandom_range(0, 4) == 0);
  endtask

  // Transaction as a list of bit slots: who drives SDA and with what value.
  task automatic buildModel();
    int n;
    logic [7:0] b;
    slotKind.delete();
    slotVal.delete();
    n       = (int'(tNum) > NB) ? NB : int'(tNum);
    expRd   = '0;
    expNack = 1'b0;
    slotKind.push_back(K_START); slotVal.push_back(1'b0);
    b = {tAddr, tRnw};
    for (int i = 7; i >= 0; i--) begin slotKind.push_back(K_MST); slotVal.push_back(b[i]); end
    slotKind.push_back(K_SLV); slotVal.push_back(tAck[0]);
    if (tAck[0]) begin
      expNack = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!tRnw) begin
          b = tWr[8*(NB-1-k) +: 8];
          for (int i = 7; i >= 0; i--) begin slotKind.push_back(K_MST); slotVal.push_back(b[i]); end
          slotKind.push_back(K_SLV); slotVal.push_back(tAck[k+1]);
          if (tAck[k+1]) begin
            expNack = 1'b1;
            break;
          end
        end else begin
          b = tRd[8*(NB-1-k) +: 8];
          for (int i = 7; i >= 0; i--) begin slotKind.push_back(K_SLV); slotVal.push_back(b[i]); end
          slotKind.push_back(K_MST); slotVal.push_back(k == n - 1);
          expRd[8*(NB-1-k) +: 8] = b;
        end
      end
    end
    slotKind.push_back(K_STOP); slotVal.push_back(1'b0);
    expLen = slotKind.size() * BITCLK;
  endtask

  // Called just after a negedge; the request is taken on the following posedge.
  task automatic applyStimulus();
    RNW       = tRnw;
    I2C_ADDR  = tAddr;
    NUM_BYTES = tNum;
    WR_DATA   = tWr;
    START_STB = 1'b1;
    @(posedge clk);
    #1;
    START_STB = 1'b0;
    buildModel();
  endtask

  task automatic runTxn(input int resetAt);
    int junkAt, slot, ph, kind;
    bit v, eScl, eOe, eOut;
    junkAt = $urandom_range(2, expLen - 1);
    for (int c = 1; c <= expLen; c++) begin
      @(negedge clk);
      slot = (c - 1) / BITCLK;
      ph   = ((c - 1) % BITCLK) / CD;
      kind = slotKind[slot];
      v    = slotVal[slot];
      SDA_IN = (kind == K_SLV) ? v : 1'b1;
      eScl = (kind == K_START) ? 1'b1 : (ph >= 2);
      eOe  = (kind != K_SLV);
      eOut = (kind == K_START) ? (ph < 2) :
             (kind == K_STOP)  ? (ph == 3) :
             (kind == K_MST)   ? v : 1'b0;
      checkOutput($sformatf("bus c%0d", c),
                  32'({BUSY, DONE, SCL, SDA_OE, SDA_OE & SDA_OUT}),
                  32'({1'b1, 1'b0, eScl, eOe, eOe & eOut}));
      if (c == 1) begin
        checkOutput("nackCleared", 32'(NACK), 32'(0));
        checkOutput("rdCleared", 32'(RD_DATA), 32'(0));
      end
      START_STB = (c == junkAt);
      if (c == junkAt) begin
        RNW       = ~tRnw;
        I2C_ADDR  = ~tAddr;
        NUM_BYTES = BW'($urandom_range(0, 3));
        WR_DATA   = ~tWr;
      end
      if (c == resetAt) begin
        RESET     = 1'b1;
        START_STB = 1'b0;
        @(negedge clk);
        RESET  = 1'b0;
        SDA_IN = 1'b1;
        expRd   = '0;
        expNack = 1'b0;
        checkOutput("rstBus", 32'({BUSY, DONE, SCL, SDA_OE, SDA_OUT}), 32'(5'b00111));
        checkOutput("rstNack", 32'(NACK), 32'(0));
        checkOutput("rstRd", 32'(RD_DATA), 32'(0));
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("postRstBus", 32'({BUSY, DONE, SCL, SDA_OE, SDA_OUT}), 32'(5'b00111));
        end
        return;
      end
    end
  endtask

  task automatic finishTxn();
    @(negedge clk);
    START_STB = 1'b0;
    SDA_IN    = 1'b1;
    checkOutput("doneBus", 32'({BUSY, DONE, SCL, SDA_OE, SDA_OUT}), 32'(5'b01111));
    checkOutput("nackFlag", 32'(NACK), 32'(expNack));
    checkOutput("rdData", 32'(RD_DATA), 32'(expRd));
  endtask

  task automatic idleCheck();
    @(negedge clk);
    checkOutput("idleBus", 32'({BUSY, DONE, SCL, SDA_OE, SDA_OUT}), 32'(5'b00111));
    checkOutput("rdHold", 32'(RD_DATA), 32'(expRd));
    checkOutput("nackHold", 32'(NACK), 32'(expNack));
  endtask

  task automatic fullTxn();
    @(negedge clk);
    applyStimulus();
    runTxn(0);
    finishTxn();
    idleCheck();
  endtask

  initial begin
    RESET     = 1'b1;
    START_STB = 1'b0;
    RNW       = 1'b0;
    I2C_ADDR  = '0;
    NUM_BYTES = '0;
    WR_DATA   = '0;
    SDA_IN    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetBus", 32'({BUSY, DONE, SCL, SDA_OE, SDA_OUT}), 32'(5'b00111));
    checkOutput("resetNack", 32'(NACK), 32'(0));
    checkOutput("resetRd", 32'(RD_DATA), 32'(0));
    RESET = 1'b0;
    expRd   = '0;
    expNack = 1'b0;
    idleCheck();

    $display("[TB] write 0x50 <- A55A");
    setTxn(1'b0, 7'h50, 2'd2, 16'hA55A, 16'h0000, 3'b000);
    fullTxn();

    $display("[TB] read 0x3C -> 1234");
    setTxn(1'b1, 7'h3C, 2'd2, 16'h0000, 16'h1234, 3'b000);
    fullTxn();

    $display("[TB] address nack");
    setTxn(1'b0, 7'h50, 2'd2, 16'hC3C3, 16'h0000, 3'b001);
    fullTxn();

    $display("[TB] address probe");
    setTxn(1'b0, 7'h21, 2'd0, 16'hFFFF, 16'h0000, 3'b000);
    fullTxn();

    $display("[TB] byte count clamp");
    setTxn(1'b0, 7'h11, 2'd3, 16'h3CA7, 16'h0000, 3'b000);
    fullTxn();
    setTxn(1'b1, 7'h12, 2'd3, 16'h0000, 16'h9E61, 3'b000);
    fullTxn();

    $display("[TB] write nack on byte0");
    setTxn(1'b0, 7'h2A, 2'd2, 16'h8001, 16'h0000, 3'b010);
    fullTxn();

    $display("[TB] reset mid-write");
    setTxn(1'b0, 7'h50, 2'd2, 16'hA55A, 16'h0000, 3'b000);
    @(negedge clk);
    applyStimulus();
    runTxn(14 * BITCLK + 6);
    setTxn(1'b0, 7'h33, 2'd1, 16'h5A00, 16'h0000, 3'b000);
    fullTxn();

    $display("[TB] randomized, some back-to-back");
    randTxn();
    @(negedge clk);
    applyStimulus();
    for (int t = 0; t < 14; t++) begin
      runTxn(0);
      finishTxn();
      randTxn();
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus();
      end else begin
        idleCheck();
        @(negedge clk);
        applyStimulus();
      end
    end
    runTxn(0);
    finishTxn();
    idleCheck();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
